pulse_monitor: RTL

Receive-side companion to the step-pulse generator. The block takes a motor step-pulse train, synchronizes it into the local clock domain and counts rising edges against an expected pulse number. It also measures the period between consecutive pulses and flags completion or a stalled train. It sits on the feedback and loopback path of the motor controller, where it closes the loop on commanded pulse counts.

---
 rtl/pulse_monitor_pkg.sv | 25 ++
 rtl/pulse_sync_edge.sv | 63 ++++++
 rtl/pulse_monitor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pulse_monitor_pkg.sv
// Shared types, default widths and helpers for the pulse monitor.
// Optional glitch filter is selected with PULSE_MONITOR_FILTER_EN.
package pulse_monitor_pkg;

   localparam int CNT_W_DEF    = 10;
   localparam int PER_W_DEF    = 15;
   localparam int TIMEOUT_DEF  = 20000;
   localparam int MIN_HIGH_DEF = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_COUNTING,
      ST_DONE,
      ST_TIMEOUT
   } state_t;

   function automatic logic [31:0] sat_inc(
      input logic [31:0] i_val,
      input logic [31:0] i_max
   );
      return (i_val >= i_max) ? i_max : i_val + 32'd1;
   endfunction

endpackage

// File: rtl/pulse_sync_edge.sv
// Synchronizer and rising-edge strobe for the step-pulse input.
// PULSE_MONITOR_FILTER_EN requires MIN_HIGH high cycles per edge.
module pulse_sync_edge
   import pulse_monitor_pkg::*;
`ifdef PULSE_MONITOR_FILTER_EN
#(
   parameter int MIN_HIGH = MIN_HIGH_DEF
)
`endif
(
   input  logic clk,
   input  logic rst,
   input  logic i_pulse,
   output logic o_edge
);

   logic r_s1;
   logic r_s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_pulse;
         r_s2 <= r_s1;
      end
   end

`ifdef PULSE_MONITOR_FILTER_EN
   localparam int RUN_W = $clog2(MIN_HIGH + 1);
   localparam logic [RUN_W-1:0] LP_LAST = RUN_W'(MIN_HIGH - 1);
   localparam logic [RUN_W-1:0] LP_SAT  = RUN_W'(MIN_HIGH);

   // r_run counts earlier consecutive high cycles; parks at MIN_HIGH
   logic [RUN_W-1:0] r_run;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run <= '0;
      end else if (!r_s2) begin
         r_run <= '0;
      end else if (r_run != LP_SAT) begin
         r_run <= r_run + RUN_W'(1);
      end
   end

   assign o_edge = r_s2 && (r_run == LP_LAST);
`else
   logic r_s3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s3 <= 1'b0;
      end else begin
         r_s3 <= r_s2;
      end
   end

   assign o_edge = r_s2 & ~r_s3;
`endif

endmodule

// File: rtl/pulse_monitor.sv
// Counts step-pulse edges against an expected number, measures period.
// PULSE_MONITOR_FILTER_EN enables the MIN_HIGH glitch filter.
module pulse_monitor
   import pulse_monitor_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int PER_W   = PER_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
`ifdef PULSE_MONITOR_FILTER_EN
   ,
   parameter int MIN_HIGH = MIN_HIGH_DEF
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Enable,
   input  logic             PulseIn,
   input  logic [CNT_W-1:0] ExpectNum,
   output logic [CNT_W-1:0] Count,
   output logic [PER_W-1:0] Period,
   output logic             Busy,
   output logic             Done,
   output logic             Timeout
);

   localparam int IDLE_W = $clog2(TIMEOUT);
   localparam logic [IDLE_W-1:0] LP_IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [31:0] LP_PER_MAX = 32'((64'd1 << PER_W) - 64'd1);

   logic w_edge;

   pulse_sync_edge
`ifdef PULSE_MONITOR_FILTER_EN
   #(.MIN_HIGH(MIN_HIGH))
`endif
   u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_pulse (PulseIn),
      .o_edge  (w_edge)
   );

   state_t            r_state;
   logic [CNT_W-1:0]  r_expect;
   logic [CNT_W-1:0]  r_count;
   logic [PER_W-1:0]  r_period;
   logic [PER_W-1:0]  r_cyc;
   logic [IDLE_W-1:0] r_idle;

   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_expect_nxt;
   logic [CNT_W-1:0]  w_count_nxt;
   logic [PER_W-1:0]  w_period_nxt;
   logic [PER_W-1:0]  w_cyc_nxt;
   logic [IDLE_W-1:0] w_idle_nxt;

   logic [PER_W-1:0]  w_cyc_inc;
   logic [CNT_W-1:0]  w_count_inc;
   logic              w_idle_end;

   assign w_cyc_inc   = PER_W'(sat_inc(32'(r_cyc), LP_PER_MAX));
   assign w_count_inc = r_count + CNT_W'(1);
   assign w_idle_end  = (r_idle == LP_IDLE_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_expect <= '0;
         r_count  <= '0;
         r_period <= '0;
         r_cyc    <= '0;
         r_idle   <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_expect <= w_expect_nxt;
         r_count  <= w_count_nxt;
         r_period <= w_period_nxt;
         r_cyc    <= w_cyc_nxt;
         r_idle   <= w_idle_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_expect_nxt = r_expect;
      w_count_nxt  = r_count;
      w_period_nxt = r_period;
      w_cyc_nxt    = r_cyc;
      w_idle_nxt   = r_idle;
      if (!Enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_expect_nxt = ExpectNum;
               w_count_nxt  = '0;
               w_period_nxt = '0;
               w_cyc_nxt    = '0;
               w_idle_nxt   = '0;
               w_state_nxt  = (ExpectNum == '0) ? ST_DONE : ST_ARMED;
            end
            ST_ARMED: begin
               // an edge on the last idle cycle beats the timeout
               if (w_edge) begin
                  w_count_nxt = CNT_W'(1);
                  w_cyc_nxt   = '0;
                  w_idle_nxt  = '0;
                  w_state_nxt = (r_expect == CNT_W'(1)) ? ST_DONE
                                                        : ST_COUNTING;
               end else if (w_idle_end) begin
                  w_state_nxt = ST_TIMEOUT;
               end else begin
                  w_idle_nxt = r_idle + IDLE_W'(1);
               end
            end
            ST_COUNTING: begin
               if (w_edge) begin
                  w_period_nxt = w_cyc_inc;
                  w_count_nxt  = w_count_inc;
                  w_cyc_nxt    = '0;
                  w_idle_nxt   = '0;
                  if (w_count_inc == r_expect) begin
                     w_state_nxt = ST_DONE;
                  end
               end else begin
                  w_cyc_nxt = w_cyc_inc;
                  if (w_idle_end) begin
                     w_state_nxt = ST_TIMEOUT;
                  end else begin
                     w_idle_nxt = r_idle + IDLE_W'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = r_state;
            end
         endcase
      end
   end

   assign Count   = r_count;
   assign Period  = r_period;
   assign Busy    = (r_state == ST_ARMED) || (r_state == ST_COUNTING);
   assign Done    = (r_state == ST_DONE);
   assign Timeout = (r_state == ST_TIMEOUT);

endmodule
